// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared state/grant types, abort data constant and arbitration helpers
// for the unified memory-port arbiter.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        GNT_DM = 2'd1,
        GNT_IF = 2'd2,
        RESP   = 2'd3
    } arb_state_e;

    typedef enum logic {
        GRANT_IF = 1'b0,
        GRANT_DM = 1'b1
    } grant_e;

    localparam logic [31:0] MEM_ARB_ABORT_DATA = 32'hDEAD_BEEF;

    // Data belongs to the older instruction, so it wins whenever it is pending.
    function automatic grant_e fixed_pick(input logic dm_pend);
        return dm_pend ? GRANT_DM : GRANT_IF;
    endfunction

    function automatic grant_e rr_pick(input logic   dm_pend,
                                       input logic   if_pend,
                                       input grant_e last_gnt);
        grant_e pick;
        if (dm_pend && if_pend) begin
            pick = (last_gnt == GRANT_DM) ? GRANT_IF : GRANT_DM;
        end else if (dm_pend) begin
            pick = GRANT_DM;
        end else begin
            pick = GRANT_IF;
        end
        return pick;
    endfunction

endpackage

// File: rtl/mem_arb_timeout.sv
// mem_arb_timeout: counts grant cycles without an ack; expired flags the cycle that
// would be the TIMEOUT-th such cycle, so the abort lands in that cycle.
module mem_arb_timeout #(
    parameter int TIMEOUT = 255
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expired
);
    localparam int               CNT_W    = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(TIMEOUT - 1);

    logic [CNT_W-1:0] r_cnt;
    logic             w_expired;

    assign w_expired = enable && (r_cnt == LAST_CNT);

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_cnt <= '0;
        end else if (clear) begin
            r_cnt <= '0;
        end else if (enable && !w_expired) begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    assign expired = w_expired;

endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one handshake memory port between fetch and data-memory stages.
// Define MEM_ARB_RR_EN for round-robin arbitration; default build is fixed data-first priority.
module mem_port_arbiter #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic [DATA_W-1:0] if_rdata,
    output logic              if_ready,
    input  logic              dm_read,
    input  logic              dm_write,
    input  logic [ADDR_W-1:0] dm_addr,
    input  logic [DATA_W-1:0] dm_wdata,
    output logic [DATA_W-1:0] dm_rdata,
    output logic              dm_ready,
    output logic              stall_if,
    output logic              stall_mem,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ack,
    output logic              mem_err
);
    import mem_arb_pkg::*;

    // state  | meaning
    // IDLE   | nothing in flight; arbitrate pending requests
    // GNT_DM | data access on the memory port, waiting for ack
    // GNT_IF | fetch access on the memory port, waiting for ack
    // RESP   | one-cycle ready pulse to the granted stage, no new grant

    localparam logic [DATA_W-1:0] ABORT_DATA = DATA_W'(MEM_ARB_ABORT_DATA);

    arb_state_e        r_state;
    arb_state_e        w_state_nxt;
    logic              r_mem_req;
    logic              w_mem_req_nxt;
    logic              r_mem_we;
    logic              w_mem_we_nxt;
    logic [ADDR_W-1:0] r_mem_addr;
    logic [ADDR_W-1:0] w_mem_addr_nxt;
    logic [DATA_W-1:0] r_mem_wdata;
    logic [DATA_W-1:0] w_mem_wdata_nxt;
    logic [DATA_W-1:0] r_if_rdata;
    logic [DATA_W-1:0] w_if_rdata_nxt;
    logic [DATA_W-1:0] r_dm_rdata;
    logic [DATA_W-1:0] w_dm_rdata_nxt;
    logic              r_if_ready;
    logic              w_if_ready_nxt;
    logic              r_dm_ready;
    logic              w_dm_ready_nxt;
    logic              r_mem_err;
    logic              w_mem_err_nxt;

    logic              w_dm_pend;
    logic              w_if_pend;
    logic              w_grant;
    logic              w_in_gnt;
    logic              w_tmo_en;
    logic              w_expired;
    grant_e            w_sel;

    assign w_dm_pend = dm_read | dm_write;
    assign w_if_pend = if_req;
    assign w_grant   = (r_state == IDLE) && (w_dm_pend || w_if_pend);
    assign w_in_gnt  = (r_state == GNT_DM) || (r_state == GNT_IF);
    assign w_tmo_en  = w_in_gnt && !mem_ack;

`ifdef MEM_ARB_RR_EN
    grant_e r_last_gnt;

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_last_gnt <= GRANT_IF;
        end else if (w_grant) begin
            r_last_gnt <= w_sel;
        end
    end

    assign w_sel = rr_pick(w_dm_pend, w_if_pend, r_last_gnt);
`else
    assign w_sel = fixed_pick(w_dm_pend);
`endif

    mem_arb_timeout #(
        .TIMEOUT (TIMEOUT)
    ) u_timeout (
        .clk     (clk),
        .rst     (rst),
        .clear   (w_grant),
        .enable  (w_tmo_en),
        .expired (w_expired)
    );

    always_comb begin
        w_state_nxt     = r_state;
        w_mem_req_nxt   = r_mem_req;
        w_mem_we_nxt    = r_mem_we;
        w_mem_addr_nxt  = r_mem_addr;
        w_mem_wdata_nxt = r_mem_wdata;
        w_if_rdata_nxt  = r_if_rdata;
        w_dm_rdata_nxt  = r_dm_rdata;
        w_if_ready_nxt  = 1'b0;
        w_dm_ready_nxt  = 1'b0;
        w_mem_err_nxt   = 1'b0;

        case (r_state)
            IDLE: begin
                if (w_grant) begin
                    w_mem_req_nxt = 1'b1;
                    if (w_sel == GRANT_DM) begin
                        w_mem_addr_nxt  = dm_addr;
                        w_mem_wdata_nxt = dm_wdata;
                        w_mem_we_nxt    = dm_write;
                        w_state_nxt     = GNT_DM;
                    end else begin
                        w_mem_addr_nxt  = if_addr;
                        w_mem_we_nxt    = 1'b0;
                        w_state_nxt     = GNT_IF;
                    end
                end
            end

            GNT_DM, GNT_IF: begin
                // An ack in the expiry cycle still completes the access normally.
                if (mem_ack) begin
                    w_mem_req_nxt = 1'b0;
                    w_state_nxt   = RESP;
                    if (r_state == GNT_IF) begin
                        w_if_rdata_nxt = mem_rdata;
                        w_if_ready_nxt = 1'b1;
                    end else begin
                        if (!r_mem_we) begin
                            w_dm_rdata_nxt = mem_rdata;
                        end
                        w_dm_ready_nxt = 1'b1;
                    end
                end else if (w_expired) begin
                    w_mem_req_nxt = 1'b0;
                    w_mem_err_nxt = 1'b1;
                    w_state_nxt   = RESP;
                    if (r_state == GNT_IF) begin
                        w_if_rdata_nxt = ABORT_DATA;
                        w_if_ready_nxt = 1'b1;
                    end else begin
                        w_dm_rdata_nxt = ABORT_DATA;
                        w_dm_ready_nxt = 1'b1;
                    end
                end
            end

            RESP: begin
                w_state_nxt = IDLE;
            end

            default: begin
                w_state_nxt   = IDLE;
                w_mem_req_nxt = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state     <= IDLE;
            r_mem_req   <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_if_rdata  <= '0;
            r_dm_rdata  <= '0;
            r_if_ready  <= 1'b0;
            r_dm_ready  <= 1'b0;
            r_mem_err   <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_mem_req   <= w_mem_req_nxt;
            r_mem_we    <= w_mem_we_nxt;
            r_mem_addr  <= w_mem_addr_nxt;
            r_mem_wdata <= w_mem_wdata_nxt;
            r_if_rdata  <= w_if_rdata_nxt;
            r_dm_rdata  <= w_dm_rdata_nxt;
            r_if_ready  <= w_if_ready_nxt;
            r_dm_ready  <= w_dm_ready_nxt;
            r_mem_err   <= w_mem_err_nxt;
        end
    end

    assign mem_req   = r_mem_req;
    assign mem_we    = r_mem_we;
    assign mem_addr  = r_mem_addr;
    assign mem_wdata = r_mem_wdata;
    assign if_rdata  = r_if_rdata;
    assign dm_rdata  = r_dm_rdata;
    assign if_ready  = r_if_ready;
    assign dm_ready  = r_dm_ready;
    assign mem_err   = r_mem_err;

    assign stall_if  = if_req & ~r_if_ready;
    assign stall_mem = w_dm_pend & ~r_dm_ready;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: transaction-level reference model (grant choice, access
// window, ready/abort cycle) compared every cycle, plus directed literal pins.
module tb_mem_port_arbiter;
    localparam int          AW    = 32;
    localparam int          DW    = 32;
    localparam int          TO    = 6;
    localparam logic [31:0] ABORT = 32'hDEAD_BEEF;

    logic          clk = 1'b0;
    logic          rst;
    logic          if_req;
    logic [AW-1:0] if_addr;
    logic [DW-1:0] if_rdata;
    logic          if_ready;
    logic          dm_read;
    logic          dm_write;
    logic [AW-1:0] dm_addr;
    logic [DW-1:0] dm_wdata;
    logic [DW-1:0] dm_rdata;
    logic          dm_ready;
    logic          stall_if;
    logic          stall_mem;
    logic          mem_req;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;
    logic          mem_ack;
    logic          mem_err;

    always #5 clk = ~clk;

    mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ready(if_ready),
        .dm_read(dm_read), .dm_write(dm_write), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
        .dm_rdata(dm_rdata), .dm_ready(dm_ready),
        .stall_if(stall_if), .stall_mem(stall_mem),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_ack(mem_ack), .mem_err(mem_err)
    );

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    bit check_en  = 1'b0;
    bit rand_mode = 1'b0;

    // directed drive values, applied at the start of the next cycle
    logic        d_rst, d_if_req, d_dm_read, d_dm_write, d_ack;
    logic [31:0] d_if_addr, d_dm_addr, d_dm_wdata, d_ack_data;
    int          dir_lat;
    logic [31:0] dir_data;

    // reference model: one transaction at a time, who=1 means data stage
    bit          m_busy, m_who, m_we, m_abort, m_last;
    logic [31:0] m_addr, m_wdata, m_data, m_if_rdata, m_dm_rdata;
    int          m_start, m_resp, m_ack_cyc;
    bit          if_done, dm_done;

    task automatic chk1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cycle %0d: got %b expected %b", name, cyc, act, exp);
        end
    endtask

    task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cycle %0d: got %h expected %h", name, cyc, act, exp);
        end
    endtask

    task automatic rand_inputs();
        rst = ($urandom_range(0, 399) != 0);
        if (if_req && (if_done || $urandom_range(0, 49) == 0)) if_req = 1'b0;
        if (!if_req && $urandom_range(0, 2) == 0) begin
            if_req  = 1'b1;
            if_addr = $urandom & 32'h0000_0FFC;
        end
        if ((dm_read || dm_write) && (dm_done || $urandom_range(0, 49) == 0)) begin
            dm_read  = 1'b0;
            dm_write = 1'b0;
        end
        if (!(dm_read || dm_write) && $urandom_range(0, 2) == 0) begin
            case ($urandom_range(0, 3))
                0, 3:    begin dm_read = 1'b1; dm_write = 1'b0; end
                1:       begin dm_read = 1'b0; dm_write = 1'b1; end
                default: begin dm_read = 1'b1; dm_write = 1'b1; end
            endcase
            dm_addr  = $urandom & 32'h0000_FFFC;
            dm_wdata = $urandom;
        end
    endtask

    task automatic compare(input bit in_win);
        bit exp_ir, exp_dr, exp_err;
        exp_ir  = m_busy && (cyc == m_resp) && !m_who;
        exp_dr  = m_busy && (cyc == m_resp) && m_who;
        exp_err = m_busy && (cyc == m_resp) && m_abort;
        chk1("mem_req", mem_req, in_win);
        if (in_win) begin
            chk32("mem_addr", mem_addr, m_addr);
            chk1("mem_we", mem_we, m_we);
            if (m_we) chk32("mem_wdata", mem_wdata, m_wdata);
        end
        chk1("if_ready", if_ready, exp_ir);
        chk1("dm_ready", dm_ready, exp_dr);
        chk1("mem_err", mem_err, exp_err);
        chk32("if_rdata", if_rdata, m_if_rdata);
        chk32("dm_rdata", dm_rdata, m_dm_rdata);
        chk1("stall_if", stall_if, if_req & ~exp_ir);
        chk1("stall_mem", stall_mem, (dm_read | dm_write) & ~exp_dr);
    endtask

    task automatic advance();
        bit dm_p;
        int lat;
        if_done = 1'b0;
        dm_done = 1'b0;
        dm_p    = dm_read || dm_write;
        if (!rst) begin
            m_busy     = 1'b0;
            m_if_rdata = '0;
            m_dm_rdata = '0;
            m_last     = 1'b0;
        end else if (m_busy) begin
            if (cyc == m_resp) begin
                if_done = !m_who;
                dm_done = m_who;
                m_busy  = 1'b0;
            end
        end else if (if_req || dm_p) begin
            if (dm_p && if_req) begin
`ifdef MEM_ARB_RR_EN
                m_who = !m_last;
`else
                m_who = 1'b1;
`endif
            end else begin
                m_who = dm_p;
            end
            m_last  = m_who;
            m_we    = m_who && dm_write;
            m_addr  = m_who ? dm_addr : if_addr;
            m_wdata = dm_wdata;
            m_start = cyc + 1;
            if (rand_mode) begin
                lat    = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, TO + 2))
                                                     : int'($urandom_range(0, 3));
                m_data = $urandom;
            end else begin
                lat    = dir_lat;
                m_data = dir_data;
            end
            if (lat < TO) begin
                m_ack_cyc = m_start + lat;
                m_resp    = m_ack_cyc + 1;
                m_abort   = 1'b0;
            end else begin
                m_ack_cyc = -1;
                m_resp    = m_start + TO;
                m_abort   = 1'b1;
            end
            m_busy = 1'b1;
        end
    endtask

    task automatic step();
        bit in_win;
        @(posedge clk);
        #1;
        cyc++;
        if (m_busy && cyc == m_resp) begin
            if (m_abort) begin
                if (m_who) m_dm_rdata = ABORT;
                else       m_if_rdata = ABORT;
            end else if (!m_who) begin
                m_if_rdata = m_data;
            end else if (!m_we) begin
                m_dm_rdata = m_data;
            end
        end
        in_win = m_busy && (cyc >= m_start) && (cyc < m_resp);
        if (rand_mode) begin
            rand_inputs();
        end else begin
            rst      = d_rst;
            if_req   = d_if_req;
            if_addr  = d_if_addr;
            dm_read  = d_dm_read;
            dm_write = d_dm_write;
            dm_addr  = d_dm_addr;
            dm_wdata = d_dm_wdata;
        end
        if (m_busy && cyc == m_ack_cyc) begin
            mem_ack   = 1'b1;
            mem_rdata = m_data;
        end else if (in_win) begin
            mem_ack   = 1'b0;
            mem_rdata = $urandom;
        end else if (rand_mode) begin
            mem_ack   = ($urandom_range(0, 4) == 0);
            mem_rdata = $urandom;
        end else begin
            mem_ack   = d_ack;
            mem_rdata = d_ack_data;
        end
        @(negedge clk);
        if (check_en) compare(in_win);
        advance();
    endtask

    initial begin
        int nreq;
        rst = 1'b0; if_req = 1'b0; if_addr = '0; dm_read = 1'b0; dm_write = 1'b0;
        dm_addr = '0; dm_wdata = '0; mem_ack = 1'b0; mem_rdata = '0;
        d_rst = 1'b0; d_if_req = 1'b0; d_dm_read = 1'b0; d_dm_write = 1'b0; d_ack = 1'b0;
        d_if_addr = '0; d_dm_addr = '0; d_dm_wdata = '0; d_ack_data = '0;
        dir_lat = 0; dir_data = '0;
        m_busy = 1'b0; m_who = 1'b0; m_we = 1'b0; m_abort = 1'b0; m_last = 1'b0;
        m_addr = '0; m_wdata = '0; m_data = '0; m_if_rdata = '0; m_dm_rdata = '0;
        m_start = 0; m_resp = 0; m_ack_cyc = -1; if_done = 1'b0; dm_done = 1'b0;

        step(); step();
        check_en = 1'b1;
        step();
        chk1("rst mem_req", mem_req, 1'b0);
        chk1("rst mem_we", mem_we, 1'b0);
        chk32("rst mem_addr", mem_addr, 32'h0);
        chk32("rst mem_wdata", mem_wdata, 32'h0);
        chk32("rst if_rdata", if_rdata, 32'h0);
        chk32("rst dm_rdata", dm_rdata, 32'h0);
        chk1("rst if_ready", if_ready, 1'b0);
        chk1("rst dm_ready", dm_ready, 1'b0);
        chk1("rst mem_err", mem_err, 1'b0);
        d_rst = 1'b1;

        // fetch only, ack on the first request cycle
        d_if_req = 1'b1; d_if_addr = 32'h40; dir_lat = 0; dir_data = 32'h8C22_0004;
        step();
        chk1("A stall_if c0", stall_if, 1'b1);
        chk1("A mem_req c0", mem_req, 1'b0);
        step();
        chk1("A mem_req c1", mem_req, 1'b1);
        chk32("A mem_addr c1", mem_addr, 32'h40);
        chk1("A stall_if c1", stall_if, 1'b1);
        step();
        chk1("A if_ready c2", if_ready, 1'b1);
        chk32("A if_rdata c2", if_rdata, 32'h8C22_0004);
        chk1("A stall_if c2", stall_if, 1'b0);
        d_if_req = 1'b0;
        step();
        chk1("A if_ready c3", if_ready, 1'b0);

        // simultaneous data read and fetch, twice: DM, IF, DM, IF
        for (int rep = 0; rep < 2; rep++) begin
            d_dm_read = 1'b1; d_dm_addr = 32'h100; d_if_req = 1'b1; d_if_addr = 32'h44;
            dir_lat = 0; dir_data = 32'h1111_0000 + 32'(rep);
            step();
            step();
            chk32("B first grant addr", mem_addr, 32'h100);
            chk1("B first grant we", mem_we, 1'b0);
            step();
            chk1("B dm_ready", dm_ready, 1'b1);
            chk32("B dm_rdata", dm_rdata, 32'h1111_0000 + 32'(rep));
            chk1("B if still stalled", stall_if, 1'b1);
            d_dm_read = 1'b0;
            step();
            chk1("B idle after resp", mem_req, 1'b0);
            step();
            chk1("B second grant req", mem_req, 1'b1);
            chk32("B second grant addr", mem_addr, 32'h44);
            step();
            chk1("B if_ready", if_ready, 1'b1);
            d_if_req = 1'b0;
            step();
        end

        // write with ack five request cycles later
        d_dm_write = 1'b1; d_dm_addr = 32'h20; d_dm_wdata = 32'h1234; dir_lat = 4;
        dir_data = 32'hCAFE_F00D;
        step();
        for (int i = 1; i <= 5; i++) begin
            step();
            chk1("C mem_req held", mem_req, 1'b1);
            chk1("C mem_we held", mem_we, 1'b1);
            chk32("C mem_wdata held", mem_wdata, 32'h1234);
        end
        step();
        chk1("C dm_ready", dm_ready, 1'b1);
        chk1("C mem_req dropped", mem_req, 1'b0);
        chk32("C dm_rdata kept", dm_rdata, 32'h1111_0001);
        d_dm_write = 1'b0;
        step();

        // read with no ack: abort after TO request cycles
        d_dm_read = 1'b1; d_dm_addr = 32'h30; dir_lat = 100;
        step();
        nreq = 0;
        for (int i = 1; i <= TO; i++) begin
            step();
            if (mem_req) nreq++;
            chk1("D no early err", mem_err, 1'b0);
        end
        chk32("D mem_req cycles", nreq, TO);
        step();
        chk1("D mem_err", mem_err, 1'b1);
        chk1("D dm_ready", dm_ready, 1'b1);
        chk32("D dm_rdata abort", dm_rdata, 32'hDEAD_BEEF);
        chk1("D mem_req low", mem_req, 1'b0);
        d_dm_read = 1'b0;
        step();

        // reset in the middle of a fetch grant; a later ack is ignored
        d_if_req = 1'b1; d_if_addr = 32'h80; dir_lat = 100;
        step();
        step();
        chk1("E mem_req in grant", mem_req, 1'b1);
        d_rst = 1'b0;
        step();
        d_rst = 1'b1; d_if_req = 1'b0; d_ack = 1'b1; d_ack_data = 32'hAAAA_5555;
        step();
        chk1("E mem_req after rst", mem_req, 1'b0);
        chk1("E no if_ready c3", if_ready, 1'b0);
        step();
        chk1("E no if_ready c4", if_ready, 1'b0);
        chk32("E if_rdata cleared", if_rdata, 32'h0);
        d_ack = 1'b0;
        step();

        rand_mode = 1'b1;
        repeat (4000) step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Sequences a single shared, handshake-based memory port between the instruction-fetch stage and the data-memory stage of the 5-stage pipeline. It replaces the separate instruction and data memories when the design moves to one unified memory. It grants one requester at a time and returns read data with a one-cycle ready pulse. It also drives per-stage stall signals that the hazard logic ORs into its PC-hold and pipeline-register hold.

## Interface
- `ADDR_W`, default 32: address width.
- `DATA_W`, default 32: data width.
- `TIMEOUT`, default 255: maximum cycles to wait for `mem_ack` before a transaction is aborted; must be ≥1.
- `clk`  in  1  clock, rising edge.
- `rst`  in  1  reset, synchronous, active-low.
- `if_req`  in  1  fetch request; held until `if_ready`.
- `if_addr`  in  ADDR_W  fetch address.
- `if_rdata`  out  DATA_W  fetched instruction; valid while `if_ready`=1.
- `if_ready`  out  1  one-cycle completion pulse for fetch.
- `dm_read`, `dm_write`  in  1 each  data request; held until `dm_ready`.
- `dm_addr`  in  ADDR_W  data address.
- `dm_wdata`  in  DATA_W  store data.
- `dm_rdata`  out  DATA_W  load data; valid while `dm_ready`=1.
- `dm_ready`  out  1  one-cycle completion pulse for data.
- `stall_if`, `stall_mem`  out  1 each  combinational; `if_req & ~if_ready` and `(dm_read|dm_write) & ~dm_ready`.
- `mem_req`  out  1  memory request; held until ack.
- `mem_we`  out  1  write strobe.
- `mem_addr`  out  ADDR_W  memory address.
- `mem_wdata`  out  DATA_W  memory write data.
- `mem_rdata`  in  DATA_W  memory read data; valid with `mem_ack`.
- `mem_ack`  in  1  memory completion.
- `mem_err`  out  1  one-cycle pulse on timeout abort.

## Operation
- FSM states: IDLE, GNT_DM, GNT_IF, RESP.
- IDLE with a data request pending: latch `dm_addr`, `dm_wdata` and `mem_we`, then go to GNT_DM.
- IDLE with only a fetch request pending: latch `if_addr` with `mem_we`=0, then go to GNT_IF.
- Priority without the configuration macro: data is always granted first, because it belongs to the older instruction.
- `dm_read`=`dm_write`=1: handled as a write.
- GNT_DM / GNT_IF:
  - `mem_req`=1 and the latched address/data are stable.
  - On `mem_ack`: capture `mem_rdata` into the granted requester's rdata register and go to RESP.
- RESP: assert the granted requester's ready for exactly one cycle, then go to IDLE. No new grant is made in RESP.
- Writes: `dm_ready` pulses as for reads; `dm_rdata` keeps its previous value.
- Timeout:
  - The counter clears on grant and increments each GNT cycle without ack.
  - On reaching `TIMEOUT`, drop `mem_req`, load rdata with 32'hDEAD_BEEF, pulse `mem_err` in the same cycle as ready, and go to RESP.
- `mem_ack` in IDLE or RESP: ignored.
- Requester drops its request mid-grant (flush): the transaction completes anyway; the ready pulse is still issued and is ignored by the stage.
- Reset: all state returns to IDLE. `mem_req`, `mem_we`, `if_ready`, `dm_ready` and `mem_err` = 0. `mem_addr`, `mem_wdata`, `if_rdata` and `dm_rdata` = 0. Timeout counter = 0. Last-grant register = IF. A reset mid-transaction abandons the access with no ready pulse.

## Timing
- All outputs are registered except `stall_if` and `stall_mem`.
- Request seen in IDLE at cycle 0: `mem_req` high from cycle 1.
- Ack at cycle k≥1: ready pulse at k+1; IDLE at k+2.
- Minimum access is 3 cycles, from request to the next accept opportunity.
- `mem_req` deasserts in the cycle after ack (RESP).
- Timeout: with no ack, abort ready occurs at cycle `TIMEOUT`+1.

## Configuration
- `MEM_ARB_RR_EN`, defined: round-robin arbitration. When both requesters are pending in IDLE, grant the one not named in the last-grant register. The register is updated on every grant.
- `MEM_ARB_RR_EN`, undefined: fixed data-first priority. The last-grant register is not instantiated.

## Structure
- Package `mem_arb_pkg` holds:
  - state enum (IDLE, GNT_DM, GNT_IF, RESP);
  - grant enum (GRANT_IF, GRANT_DM);
  - constant `MEM_ARB_ABORT_DATA` = 32'hDEAD_BEEF.
- One sub-module, `mem_arb_timeout`: parameterised cycle counter with `clear`/`enable` inputs and an `expired` output, width `$clog2(TIMEOUT+1)`.

## Test plan
- Fetch only: `if_req`, `if_addr`=0x40, ack on the first `mem_req` cycle with `mem_rdata`=0x8C220004 -> `if_ready` and `if_rdata`=0x8C220004 exactly 2 cycles after the request; `stall_if`=1 until then.
- Simultaneous `dm_read` at 0x100 and `if_req` at 0x44, macro off -> data granted first (`mem_addr`=0x100); fetch granted in the cycle after `dm_ready`'s RESP.
- Same stimulus repeated twice with `MEM_ARB_RR_EN` -> grants alternate DM, IF, DM, IF.
- `dm_write`, addr 0x20, data 0x1234, ack delayed 5 cycles -> `mem_we`=1 and `mem_wdata`=0x1234 stable for 5 cycles; `dm_ready` one cycle after ack; `dm_rdata` unchanged.
- No ack with `TIMEOUT`=4 -> `mem_req` for 4 cycles, then `mem_err` and `dm_ready` together with `dm_rdata`=0xDEADBEEF.
- Reset (`rst`=0) during GNT_IF -> next cycle `mem_req`=0 and FSM in IDLE; no `if_ready`; a subsequent ack is ignored.
